traffic_light_ctrl_param: RTL and testbench

//  Parametrised, demand-actuated two-road intersection controller: full G->Y->all-red cycle per road.

---
 rtl/traffic_light_ctrl_param_pkg.sv | 31 +++
 rtl/traffic_light_ctrl_param_phase_timer.sv | 53 +++++
 rtl/traffic_light_ctrl_param.sv | 191 +++++++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : traffic_pkg
//  Description : Shared types and constants for the two-road traffic light
//                controller. Holds the controller state encoding, which is
//                also the value driven on the 'phase' monitoring port, and
//                the one-hot lamp constants {Red,Yellow,Green}.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // Controller states. The numeric values are visible on the 'phase' port.
    // FLASH is reachable only when FLASH_MODE_EN is defined.
    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_e;

    // Lamp head vectors, ordered {Red,Yellow,Green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_light_ctrl_param_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Phase duration counter. Cleared to zero by i_clear,
//                otherwise counts up once per cycle and saturates at
//                (i_duration - 1). o_expired is high while the count sits
//                at that final value, so a phase that leaves on o_expired
//                lasts exactly i_duration cycles.
//  Ports       : clk        in  clock
//                rst        in  synchronous active-high reset
//                i_clear    in  restart count at zero on next edge
//                i_duration in  duration of the current phase (>= 1)
//                o_expired  out count has reached i_duration - 1
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic [TIMER_W-1:0] i_duration,
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count_q;
    logic [TIMER_W-1:0] w_count_d;
    logic [TIMER_W-1:0] w_last;

    assign w_last    = i_duration - TIMER_W'(1);
    assign o_expired = (r_count_q == w_last);

    // Clear wins; otherwise increment until the final value is reached and
    // then hold there, so the counter can never wrap.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (r_count_q != w_last) begin
            w_count_d = r_count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl_param
//  Description : Demand-actuated two-road intersection controller. Each road
//                runs green -> yellow -> all-red; green is held until the
//                minimum green has elapsed and the cross road requests
//                service. Lamp outputs are decoded from registered state
//                only (Moore), so inputs never reach the lamps directly.
//  Build macro : FLASH_MODE_EN - when defined, 'flash' forces a flashing
//                yellow mode (both heads YEL/OFF alternating every
//                FLASH_HALF cycles); leaving it goes through AR2. When
//                undefined, 'flash' is ignored and lamps are never dark.
//  Ports       : clk     in   clock
//                reset   in   synchronous active-high reset (highest priority)
//                ns_req  in   vehicle waiting on North-South road (level)
//                ew_req  in   vehicle waiting on East-West road (level)
//                flash   in   flashing-yellow request
//                NS      out  NS lamps {R,Y,G}
//                EW      out  EW lamps {R,Y,G}
//                phase   out  current state encoding (traffic_pkg::state_e)
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_light_ctrl_param
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME  = 5,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int FLASH_HALF  = 4,
    parameter int TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       flash,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic [2:0] phase
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks: the timer must never wrap and
    // every phase must last at least one cycle.
    // ------------------------------------------------------------------
    localparam int c_timer_lim = 2 ** TIMER_W;

    generate
        if (GREEN_TIME < 1 || GREEN_TIME >= c_timer_lim) begin : g_bad_green
            $error("GREEN_TIME out of range for TIMER_W");
        end
        if (YELLOW_TIME < 1 || YELLOW_TIME >= c_timer_lim) begin : g_bad_yellow
            $error("YELLOW_TIME out of range for TIMER_W");
        end
        if (ALLRED_TIME < 1 || ALLRED_TIME >= c_timer_lim) begin : g_bad_allred
            $error("ALLRED_TIME out of range for TIMER_W");
        end
        if (FLASH_HALF < 1 || FLASH_HALF >= c_timer_lim) begin : g_bad_flash
            $error("FLASH_HALF out of range for TIMER_W");
        end
    endgenerate

    localparam logic [TIMER_W-1:0] c_green_dur  = TIMER_W'(GREEN_TIME);
    localparam logic [TIMER_W-1:0] c_yellow_dur = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] c_allred_dur = TIMER_W'(ALLRED_TIME);
    localparam logic [TIMER_W-1:0] c_flash_dur  = TIMER_W'(FLASH_HALF);

    state_e             r_state_q;
    state_e             w_state_d;
    logic [TIMER_W-1:0] w_duration;
    logic               w_expired;
    logic               w_clear;

    // ------------------------------------------------------------------
    // Duration of the phase currently being timed.
    // ------------------------------------------------------------------
    always_comb begin
        w_duration = c_green_dur;
        case (r_state_q)
            NS_G, EW_G: w_duration = c_green_dur;
            NS_Y, EW_Y: w_duration = c_yellow_dur;
            AR1,  AR2:  w_duration = c_allred_dur;
            FLASH:      w_duration = c_flash_dur;
            default:    w_duration = c_green_dur;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. Green waits for both minimum time and a cross-road
    // request; because the request is a level and the timer saturates, an
    // early request is simply re-evaluated every cycle until it is served.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            NS_G:    if (w_expired && ew_req) w_state_d = NS_Y;
            NS_Y:    if (w_expired)           w_state_d = AR1;
            AR1:     if (w_expired)           w_state_d = EW_G;
            EW_G:    if (w_expired && ns_req) w_state_d = EW_Y;
            EW_Y:    if (w_expired)           w_state_d = AR2;
            AR2:     if (w_expired)           w_state_d = NS_G;
`ifdef FLASH_MODE_EN
            FLASH:   if (!flash)              w_state_d = AR2;
`endif
            default:                          w_state_d = NS_G;
        endcase
`ifdef FLASH_MODE_EN
        // Flash request overrides normal sequencing from any state.
        if (flash) begin
            w_state_d = FLASH;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= NS_G;
        end else begin
            r_state_q <= w_state_d;
        end
    end

`ifdef FLASH_MODE_EN
    // ------------------------------------------------------------------
    // Flash lamp phase. Held at 1 outside FLASH so that entry always starts
    // with the lit half; toggles each time a half period expires. The timer
    // is restarted at every half-period boundary to keep it counting.
    // ------------------------------------------------------------------
    logic r_flash_on_q;
    logic w_flash_on_d;

    always_comb begin
        w_flash_on_d = r_flash_on_q;
        if (r_state_q != FLASH) begin
            w_flash_on_d = 1'b1;
        end else if (w_expired) begin
            w_flash_on_d = ~r_flash_on_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flash_on_q <= 1'b1;
        end else begin
            r_flash_on_q <= w_flash_on_d;
        end
    end

    assign w_clear = (w_state_d != r_state_q) ||
                     ((r_state_q == FLASH) && w_expired);
`else
    logic w_unused_flash;
    assign w_unused_flash = flash;
    assign w_clear        = (w_state_d != r_state_q);
`endif

    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_clear),
        .i_duration (w_duration),
        .o_expired  (w_expired)
    );

    // ------------------------------------------------------------------
    // Lamp decode from registered state only.
    // ------------------------------------------------------------------
    always_comb begin
        NS = RED;
        EW = RED;
        case (r_state_q)
            NS_G:    begin NS = GRN; EW = RED; end
            NS_Y:    begin NS = YEL; EW = RED; end
            EW_G:    begin NS = RED; EW = GRN; end
            EW_Y:    begin NS = RED; EW = YEL; end
`ifdef FLASH_MODE_EN
            FLASH:   begin
                NS = r_flash_on_q ? YEL : OFF;
                EW = r_flash_on_q ? YEL : OFF;
            end
`endif
            default: begin NS = RED; EW = RED; end
        endcase
    end

    assign phase = r_state_q;

endmodule : traffic_light_ctrl_param
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl_param
//  Description : Self-checking bench for traffic_light_ctrl_param. A
//                behavioural model tracks the current phase and the number
//                of cycles spent in it, and derives lamps from the phase
//                table; DUT outputs are compared after every clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl_param;
    import traffic_pkg::*;

    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int FH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ns_req;
    logic       ew_req;
    logic       flash;
    logic [2:0] ns_l;
    logic [2:0] ew_l;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_light_ctrl_param #(
        .GREEN_TIME  (G),
        .YELLOW_TIME (Y),
        .ALLRED_TIME (AR),
        .FLASH_HALF  (FH),
        .TIMER_W     (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ns_req (ns_req),
        .ew_req (ew_req),
        .flash  (flash),
        .NS     (ns_l),
        .EW     (ew_l),
        .phase  (phase)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase name plus cycles elapsed in that phase.
    // ------------------------------------------------------------------
    state_e m_state = NS_G;
    int     m_el    = 0;

`ifdef FLASH_MODE_EN
    localparam bit c_flash_en = 1'b1;
`else
    localparam bit c_flash_en = 1'b0;
`endif

    function automatic int dur_of(state_e s);
        case (s)
            NS_G, EW_G: return G;
            NS_Y, EW_Y: return Y;
            default:    return AR;
        endcase
    endfunction

    function automatic logic [5:0] lamps_of(state_e s, int el);
        case (s)
            NS_G:     return {GRN, RED};
            NS_Y:     return {YEL, RED};
            AR1, AR2: return {RED, RED};
            EW_G:     return {RED, GRN};
            EW_Y:     return {RED, YEL};
            FLASH:    return (((el / FH) % 2) == 0) ? {YEL, YEL} : {OFF, OFF};
            default:  return {OFF, OFF};
        endcase
    endfunction

    task automatic model_step();
        state_e nxt;
        bit     done;
        nxt  = m_state;
        done = (m_el >= dur_of(m_state) - 1);
        if (reset) begin
            m_state = NS_G;
            m_el    = 0;
            return;
        end
        if (c_flash_en && flash) begin
            nxt = FLASH;
        end else begin
            case (m_state)
                NS_G:  if (done && ew_req) nxt = NS_Y;
                NS_Y:  if (done)           nxt = AR1;
                AR1:   if (done)           nxt = EW_G;
                EW_G:  if (done && ns_req) nxt = EW_Y;
                EW_Y:  if (done)           nxt = AR2;
                AR2:   if (done)           nxt = NS_G;
                FLASH:                     nxt = AR2;
                default:                   nxt = NS_G;
            endcase
        end
        if (nxt != m_state) begin
            m_state = nxt;
            m_el    = 0;
        end else begin
            m_el++;
        end
    endtask

    function automatic bit lamp_legal(logic [2:0] v, logic [2:0] ph);
        if (v == GRN || v == YEL || v == RED) return 1'b1;
        return (v == OFF) && c_flash_en && (ph == 3'(FLASH));
    endfunction

    // One clock: inputs already applied; advance model, then compare.
    task automatic cycle();
        logic [5:0] exp_l;
        @(posedge clk);
        model_step();
        #1;
        exp_l = lamps_of(m_state, m_el);
        check_val("phase", 32'(phase), 32'(m_state));
        check_val("ns_lamp", 32'(ns_l), 32'(exp_l[5:3]));
        check_val("ew_lamp", 32'(ew_l), 32'(exp_l[2:0]));
        check_val("ns_legal", 32'(lamp_legal(ns_l, phase)), 32'd1);
        check_val("ew_legal", 32'(lamp_legal(ew_l, phase)), 32'd1);
        check_val("both_go", 32'((ns_l != RED) && (ew_l != RED) &&
                                 (ns_l != OFF) && (ew_l != OFF)), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        ns_req = 1'b0;
        ew_req = 1'b0;
        flash  = 1'b0;

        // Reset held three cycles, then idle: NS must stay green.
        repeat (3) cycle();
        reset = 1'b0;
        repeat (30) cycle();

        // Early short EW pulse must be ignored; sustained request later is served.
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 26; i++) begin
            ew_req = (i == 2) || (i >= 20);
            cycle();
        end

        // Both roads requesting continuously: full 16-cycle rotation.
        ns_req = 1'b1;
        ew_req = 1'b1;
        repeat (48) cycle();

        // Reset in the middle of EW yellow.
        begin
            int budget;
            budget = 0;
            while (m_state != EW_Y && budget < 40) begin
                cycle();
                budget++;
            end
            check_val("reach_ew_y", 32'(m_state == EW_Y), 32'd1);
            reset = 1'b1;
            cycle();
            reset = 1'b0;
            ns_req = 1'b0;
            repeat (12) cycle();
        end

`ifdef FLASH_MODE_EN
        // Flash entered from EW green, then released.
        begin
            int budget;
            ns_req = 1'b0;
            ew_req = 1'b1;
            budget = 0;
            while (m_state != EW_G && budget < 40) begin
                cycle();
                budget++;
            end
            check_val("reach_ew_g", 32'(m_state == EW_G), 32'd1);
            flash = 1'b1;
            repeat (20) cycle();
            flash = 1'b0;
            repeat (6) cycle();
        end
`endif

        // Randomised traffic with occasional resets (and flash episodes).
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias   = (i / 500) % 3;
            ns_req = ($urandom_range(0, 9) < 3 * bias + 1);
            ew_req = ($urandom_range(0, 9) < 9 - 3 * bias);
            reset  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) flash = ~flash;
            cycle();
        end

        reset = 1'b0;
        flash = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_traffic_light_ctrl_param
`default_nettype wire
